// File: rtl/cache_miss_handler.sv
// Miss handler: optional dirty-victim write-back, then a full-block fill, one word per memory beat.
// Fill words stream straight into the cache data array; a done pulse releases the lookup stage.
module cache_miss_handler #(
    parameter int ADD_SZ     = 26,
    parameter int TAG_SZ     = 11,
    parameter int IND_SZ     = 9,
    parameter int BLK_OFF_SZ = 6,
    parameter int B          = 64,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADD_SZ-1:0]     miss_addr,
    input  logic                  victim_dirty,
    input  logic [TAG_SZ-1:0]     victim_tag,
    output logic [BLK_OFF_SZ-1:0] vdata_idx,
    input  logic [W-1:0]          vdata,
    output logic                  fill_we,
    output logic [BLK_OFF_SZ-1:0] fill_idx,
    output logic [W-1:0]          fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADD_SZ-1:0]     mem_addr,
    output logic [W-1:0]          mem_wdata,
    input  logic [W-1:0]          mem_rdata,
    input  logic                  mem_ack,
    output logic                  done,
    output logic [31:0]           fill_count,
    output logic [31:0]           wb_count
);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    localparam logic [BLK_OFF_SZ-1:0] LAST = BLK_OFF_SZ'(B - 1);

    state_t                  state;
    logic [TAG_SZ-1:0]       tag_q;
    logic [TAG_SZ-1:0]       vtag_q;
    logic [IND_SZ-1:0]       index_q;
    logic [BLK_OFF_SZ-1:0]   beat;

    // Blocks are always fetched from word 0, so the requested offset is never used.
    logic unused_offset;
    assign unused_offset = ^miss_addr[BLK_OFF_SZ-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            miss_ready <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            fill_count <= '0;
            wb_count   <= '0;
            beat       <= '0;
            tag_q      <= '0;
            vtag_q     <= '0;
            index_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        tag_q      <= miss_addr[ADD_SZ-1 -: TAG_SZ];
                        index_q    <= miss_addr[BLK_OFF_SZ +: IND_SZ];
                        vtag_q     <= victim_tag;
                        beat       <= '0;
                        miss_ready <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_we     <= victim_dirty;
                        state      <= victim_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (beat == LAST) begin
                            beat     <= '0;
                            wb_count <= wb_count + 32'd1;
                            mem_we   <= 1'b0;
                            state    <= FILL;
                        end else begin
                            beat <= beat + BLK_OFF_SZ'(1);
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (beat == LAST) begin
                            beat    <= '0;
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            beat <= beat + BLK_OFF_SZ'(1);
                        end
                    end
                end
                DONE: begin
                    fill_count <= fill_count + 32'd1;
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data paths are decoded from state so they read zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        vdata_idx = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        case (state)
            WB: begin
                mem_addr  = {vtag_q, index_q, beat};
                vdata_idx = beat;
                mem_wdata = vdata;
            end
            FILL: begin
                mem_addr  = {tag_q, index_q, beat};
                fill_we   = mem_ack;
                fill_idx  = beat;
                fill_data = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: a table of miss scenarios checked beat by beat,
// plus hand sequences for reset-in-WB, back-to-back misses and spurious acks.
module tb_cache_miss_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [25:0] miss_addr;
    logic        victim_dirty;
    logic [10:0] victim_tag;
    logic [5:0]  vdata_idx;
    logic [7:0]  vdata;
    logic        fill_we;
    logic [5:0]  fill_idx;
    logic [7:0]  fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        done;
    logic [31:0] fill_count;
    logic [31:0] wb_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Victim array and memory are simple functions of their address.
    assign vdata     = {2'b00, vdata_idx} ^ 8'hA5;
    assign mem_rdata = mem_addr[7:0] ^ 8'h3C;

    cache_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .vdata_idx(vdata_idx), .vdata(vdata),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .fill_count(fill_count), .wb_count(wb_count)
    );

    typedef struct {
        logic [25:0] addr;
        logic [10:0] vtag;
        logic        dirty;
        int          period;
        int          exp_done;
        int          exp_fill;
        int          exp_wb;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; miss_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one miss and checks every cycle against a beat-level model.
    task automatic run_miss(input vec_t v, input bit pre_reset);
        int         phase;
        int         beat;
        int         fills;
        int         done_cyc;
        logic [5:0] b6;
        logic [25:0] ea;
        if (pre_reset) do_reset();
        phase = v.dirty ? 0 : 1;
        beat = 0; fills = 0; done_cyc = -1;
        @(negedge clk);
        miss_valid = 1'b1; miss_addr = v.addr; victim_tag = v.vtag; victim_dirty = v.dirty;
        mem_ack = 1'b1;
        #1;
        chk("accept_ready", 64'(miss_ready), 64'd1);
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk);
            miss_valid = 1'b0; miss_addr = ~v.addr; victim_tag = ~v.vtag; victim_dirty = ~v.dirty;
            mem_ack = ((cyc % v.period) == 0);
            #1;
            if (phase == 2) begin
                chk("done_state", 64'({mem_req, fill_we, done, miss_ready}), 64'(4'b0010));
                done_cyc = cyc;
                break;
            end
            b6 = 6'(beat);
            if (phase == 0) begin
                ea = {v.vtag, v.addr[14:6], b6};
                chk("wb_beat", 64'({mem_req, mem_we, mem_addr, mem_wdata, fill_we, vdata_idx, done, miss_ready}),
                    64'({1'b1, 1'b1, ea, ({2'b00, b6} ^ 8'hA5), 1'b0, b6, 1'b0, 1'b0}));
            end else begin
                ea = {v.addr[25:6], b6};
                chk("fill_beat", 64'({mem_req, mem_we, mem_addr, fill_we, fill_idx, fill_data, done, miss_ready}),
                    64'({1'b1, 1'b0, ea, mem_ack, b6, (ea[7:0] ^ 8'h3C), 1'b0, 1'b0}));
            end
            if (mem_ack) begin
                if (phase == 1) fills++;
                beat++;
                if (beat == 64) begin
                    beat = 0;
                    phase++;
                end
            end
        end
        chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        chk("fill_pulses", 64'(fills), 64'd64);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("ready_after", 64'(miss_ready), 64'd1);
        chk("fill_count", 64'(fill_count), 64'(v.exp_fill));
        chk("wb_count", 64'(wb_count), 64'(v.exp_wb));
    endtask

    vec_t tbl [4];
    vec_t clean0;

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; victim_tag = '0; victim_dirty = 1'b0; mem_ack = 1'b0;

        tbl[0] = '{26'h0123456,                  11'h3AB, 1'b0, 1, 65,  1, 0};
        tbl[1] = '{{11'h155, 9'h1A5, 6'h2A},     11'h7FF, 1'b1, 1, 129, 1, 1};
        tbl[2] = '{26'h2ABCDEF,                  11'h155, 1'b0, 3, 193, 1, 0};
        tbl[3] = '{26'h1F0F0C3,                  11'h001, 1'b1, 2, 257, 1, 1};

        // Reset state
        do_reset();
        #1;
        chk("reset_ctrl", 64'({miss_ready, mem_req, mem_we, fill_we, done}), 64'(5'b10000));
        chk("reset_counts", {fill_count, wb_count}, 64'd0);
        chk("reset_paths", 64'({mem_addr, mem_wdata, vdata_idx, fill_idx, fill_data}), 64'd0);

        foreach (tbl[i]) run_miss(tbl[i], 1'b1);

        // Reset during write-back beat 10, after a completed miss left the counters non-zero
        run_miss(tbl[0], 1'b1);
        @(negedge clk);
        miss_valid = 1'b1; miss_addr = 26'h0A0A0A0; victim_tag = 11'h7FF; victim_dirty = 1'b1; mem_ack = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            miss_valid = 1'b0;
            #1;
            if (cyc == 11) begin
                chk("wb_beat10_addr", 64'(mem_addr), 64'({11'h7FF, 9'h082, 6'd10}));
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        chk("rst_wb_ctrl", 64'({mem_req, mem_we, miss_ready, done, fill_we}), 64'(5'b00100));
        chk("rst_wb_counts", {fill_count, wb_count}, 64'd0);
        clean0 = tbl[0];
        run_miss(clean0, 1'b0);

        // Back-to-back: miss_valid held; second address shows up once the first is latched
        do_reset();
        @(negedge clk);
        miss_valid = 1'b1; miss_addr = 26'h0123456; victim_dirty = 1'b0; victim_tag = '0; mem_ack = 1'b1;
        for (int cyc = 1; cyc <= 132; cyc++) begin
            @(negedge clk);
            miss_addr = 26'h3C0FFEE;
            if (cyc == 67) miss_valid = 1'b0;
            #1;
            if (cyc == 65) chk("b2b_done1", 64'({done, miss_ready}), 64'(2'b10));
            if (cyc == 66) chk("b2b_ready", 64'({done, miss_ready}), 64'(2'b01));
            if (cyc == 67) chk("b2b_second_addr", 64'({mem_req, mem_we, mem_addr}), 64'({2'b10, 20'hF03FF, 6'd0}));
            if (cyc == 131) chk("b2b_done2", 64'(done), 64'd1);
            if (cyc == 132) chk("b2b_fill_count", 64'(fill_count), 64'd2);
        end

        // Spurious acks while idle
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            miss_valid = 1'b0; mem_ack = 1'b1;
            #1;
            chk("spurious_ack", 64'({mem_req, fill_we, done, miss_ready}), 64'(4'b0001));
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("spurious_counts", {fill_count, wb_count}, {32'd2, 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss/write-back controller that sits directly downstream of the cache tag/lookup stage. On each miss it evicts the victim block to main memory if the victim is dirty, then fetches the missing block one word per beat. Fetched words are written into the cache data array. A done pulse releases the lookup stage for the next access. It also keeps running counts of fills and write-backs for the end-of-trace statistics.

## Interface
- ADD_SZ, 26, word-address width (TAG_SZ + IND_SZ + BLK_OFF_SZ)
- TAG_SZ, 11, tag width
- IND_SZ, 9, set-index width
- BLK_OFF_SZ, 6, block-offset width
- B, 64, words per block (must equal 2^BLK_OFF_SZ)
- W, 8, bits per word

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  lookup stage presents a miss
- miss_ready  out  1  handler can accept a miss
- miss_addr  in  ADD_SZ  missing word address {tag, index, offset}
- victim_dirty  in  1  selected victim way is valid and modified
- victim_tag  in  TAG_SZ  tag of the victim way
- vdata_idx  out  BLK_OFF_SZ  word index to read from the victim block
- vdata  in  W  victim word at vdata_idx (combinational read, same cycle)
- fill_we  out  1  write one fetched word into the cache data array
- fill_idx  out  BLK_OFF_SZ  word index for fill_we
- fill_data  out  W  word for fill_we
- mem_req  out  1  main-memory request
- mem_we  out  1  1 = write (write-back), 0 = read (fill)
- mem_addr  out  ADD_SZ  memory word address
- mem_wdata  out  W  write data
- mem_rdata  in  W  read data, valid with mem_ack
- mem_ack  in  1  memory completes the current beat
- done  out  1  one-cycle pulse when the fill completes
- fill_count  out  32  completed fills
- wb_count  out  32  completed write-backs

## Operation
- FSM states: IDLE, WB, FILL, DONE.
- **IDLE**
  - miss_ready = 1.
  - On miss_valid & miss_ready, latch tag, index, victim_tag and victim_dirty, and clear beat to 0.
  - Next state is WB if victim_dirty, else FILL.
- **WB**
  - mem_req = 1, mem_we = 1.
  - mem_addr = {victim_tag, index, beat}.
  - vdata_idx = beat, mem_wdata = vdata.
  - On mem_ack: beat += 1.
  - On mem_ack with beat == B-1: wb_count += 1, beat clears to 0, next state FILL.
- **FILL**
  - mem_req = 1, mem_we = 0.
  - mem_addr = {tag, index, beat}.
  - fill_we = mem_ack (combinational); fill_idx = beat; fill_data = mem_rdata.
  - On mem_ack: beat += 1.
  - On mem_ack with beat == B-1: next state DONE.
- **DONE**
  - done = 1 and fill_count += 1 for exactly one cycle.
  - Next state IDLE.
- Blocks are always fetched in ascending order from offset 0; the latched offset bits are ignored.
- beat is BLK_OFF_SZ bits wide. It wraps only through its explicit clear, never through overflow into the next block.
- Counters are free-running modulo 2^32.
- mem_ack is ignored in IDLE and DONE.
- miss_valid is ignored outside IDLE; the lookup stage must hold the request until it is accepted.
- miss_addr, victim_tag and victim_dirty are sampled only at acceptance. Later changes have no effect.

## Timing
- **Reset values:** state IDLE, miss_ready = 1, mem_req = 0, mem_we = 0, fill_we = 0, done = 0, all counters 0. mem_addr, mem_wdata, vdata_idx, fill_idx and fill_data are 0.
- **Reset mid-operation:** rst is asserted in any state. From the cycle after the reset edge the block is in IDLE with the reset values above. The in-flight beat is abandoned and no counters advance.
- **Memory handshake**
  - While mem_req = 1, mem_addr, mem_we and mem_wdata are held stable until the cycle mem_ack = 1.
  - mem_ack may be 1 in the first cycle of mem_req (zero wait state).
  - The next beat's request follows in the next cycle with no idle gap.
- **Latency, clean miss, zero wait:** accepted at cycle 0; FILL beats at cycles 1..B; done at cycle B+1; miss_ready = 1 at cycle B+2.
- **Latency, dirty miss:** add B cycles, plus one extra cycle per wait state.
- **Back-to-back misses:** a new miss is accepted at the earliest in the cycle after done.
- All outputs other than fill_we, fill_data, mem_wdata and mem_addr are registered or state-decoded. fill_we and fill_data pass mem_ack and mem_rdata through combinationally.

## Test plan
- **Clean miss, zero wait:** miss_addr = 0x0123456, victim_dirty = 0, mem_ack held at 1 → 64 read beats at addresses 0x0123440..0x012347F. fill_we is 1 in those 64 cycles with fill_idx 0..63. done at cycle 65, fill_count = 1, wb_count = 0.
- **Dirty miss:** victim_tag = 0x7FF, index = 0x1A5, mem_ack held at 1 → first 64 write beats at {0x7FF, 0x1A5, 0..63} with mem_wdata = vdata at vdata_idx. Then 64 read beats, then done. wb_count = 1, fill_count = 1.
- **Wait states:** mem_ack = 1 only every 3rd cycle of a clean miss → mem_addr stable across the stalls, exactly 64 fill_we pulses, done at cycle 193.
- **Reset in WB:** assert rst at WB beat 10 → next cycle mem_req = 0, miss_ready = 1, both counters 0. A new clean miss then completes normally.
- **Back-to-back:** miss_valid held high with two different addresses → second accepted the cycle after the first done, fill_count = 2.
- **Spurious ack:** mem_ack pulsed while IDLE → no fill_we, no state change, counters unchanged.
